// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: word-addressed prefetcher feeding a small FIFO that
// hands {instr, instr_pc} to issue over a valid/ready handshake. At most one
// memory read is outstanding; its FIFO slot is reserved when it is issued.
// A redirect reloads the fetch PC and flushes the queue.
// Optional build macro IFU_STALL_COUNT_EN adds the stall_cycles counter output.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_read_address,
    output logic        mem_read_req,
    input  logic        mem_grant,
    input  logic [31:0] mem_read_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef IFU_STALL_COUNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      cap_pc_q, cap_pc_d;
    logic             inflight_q, inflight_d;
    logic             squash_q, squash_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      data_mem_q [DEPTH];
    logic [31:0]      pc_mem_q   [DEPTH];

    logic [CNT_W-1:0] occ_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;

    assign mem_read_address = fetch_pc_q;
    assign instr            = data_mem_q[head_q];
    assign instr_pc         = pc_mem_q[head_q];

    // Request/handshake decode and next-state for PC, in-flight tracking and FIFO pointers
    always_comb begin
        occ_s        = count_q + {{(CNT_W-1){1'b0}}, inflight_q};
        instr_valid  = (count_q != {CNT_W{1'b0}});
        mem_read_req = !rst && !redirect_valid && (occ_s < CNT_W'(DEPTH));
        accept_s     = mem_read_req && mem_grant;
        pop_s        = instr_valid && instr_ready;
        // A return landing in a redirect cycle is dropped along with the flush
        push_s       = inflight_q && !squash_q && !redirect_valid;

        fetch_pc_d = fetch_pc_q;
        cap_pc_d   = cap_pc_q;
        inflight_d = accept_s;
        squash_d   = squash_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end else if (accept_s) begin
            fetch_pc_d = fetch_pc_q + 32'd1;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        if (accept_s) begin
            cap_pc_d = fetch_pc_q;
        end else begin
            cap_pc_d = cap_pc_q;
        end

        // Any read still outstanding after a redirect edge is stale; clear on its return
        if (redirect_valid) begin
            squash_d = inflight_d;
        end else if (inflight_q) begin
            squash_d = 1'b0;
        end else begin
            squash_d = squash_q;
        end

        if (pop_s) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end

        // Flush keeps the head where it is so instr/instr_pc hold their last values
        if (redirect_valid) begin
            tail_d  = head_d;
            count_d = {CNT_W{1'b0}};
        end else begin
            tail_d  = push_s ? (tail_q + PTR_W'(1)) : tail_q;
            count_d = count_q + {{(CNT_W-1){1'b0}}, push_s}
                              - {{(CNT_W-1){1'b0}}, pop_s};
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            cap_pc_q   <= 32'h0;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
            head_q     <= {PTR_W{1'b0}};
            tail_q     <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            cap_pc_q   <= cap_pc_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage: cleared on reset, written at the tail on each accepted return
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_mem_q[i] <= 32'h0;
                pc_mem_q[i]   <= 32'h0;
            end
        end else if (push_s) begin
            data_mem_q[tail_q] <= mem_read_data;
            pc_mem_q[tail_q]   <= cap_pc_q;
        end else begin
            data_mem_q[tail_q] <= data_mem_q[tail_q];
            pc_mem_q[tail_q]   <= pc_mem_q[tail_q];
        end
    end

`ifdef IFU_STALL_COUNT_EN
    logic [31:0] stall_cycles_q;

    assign stall_cycles = stall_cycles_q;

    // Saturating count of cycles where issue was ready but nothing was queued
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'h0;
        end else if (instr_ready && !instr_valid && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end else begin
            stall_cycles_q <= stall_cycles_q;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit. Memory model returns 0x1000+address
// one cycle after an accepted request. Stall-counter checks are compiled in
// when IFU_STALL_COUNT_EN is defined.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_read_address;
    logic        mem_read_req;
    logic        mem_grant;
    logic [31:0] mem_read_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFU_STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read_address (mem_read_address),
        .mem_read_req     (mem_read_req),
        .mem_grant        (mem_grant),
        .mem_read_data    (mem_read_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc)
`ifdef IFU_STALL_COUNT_EN
        ,
        .stall_cycles     (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, poison value when nothing was accepted
    always @(posedge clk) begin
        if (mem_read_req && mem_grant) begin
            mem_read_data <= 32'h1000 + mem_read_address;
        end else begin
            mem_read_data <= 32'hDEAD_BEEF;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int exp_pc;
        int exp_req;

        // ---------------- Cold start ----------------
        rst = 1'b1; mem_grant = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_req", {31'd0, mem_read_req}, 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_pc", instr_pc, 32'h0);
        rst = 1'b0; #1;
        check_eq("cold_req", {31'd0, mem_read_req}, 32'd1);
        check_eq("cold_addr0", mem_read_address, 32'h0);
        tick();
        check_eq("cold_valid_n1", {31'd0, instr_valid}, 32'd0);
        check_eq("cold_addr1", mem_read_address, 32'h1);
        tick();
        check_eq("cold_first_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("cold_first_instr", instr, 32'h1000);
        check_eq("cold_first_pc", instr_pc, 32'h0);
`ifdef IFU_STALL_COUNT_EN
        check_eq("stall_first", stall_cycles, 32'd2);
`endif
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_eq("cold_stream_valid", {31'd0, instr_valid}, 32'd1);
            check_eq("cold_stream_pc", instr_pc, 32'(k));
            check_eq("cold_stream_instr", instr, 32'h1000 + 32'(k));
`ifdef IFU_STALL_COUNT_EN
            check_eq("stall_flow", stall_cycles, 32'd2);
`endif
        end

        // ---------------- Backpressure ----------------
        rst = 1'b1; tick();
        rst = 1'b0; instr_ready = 1'b0; mem_grant = 1'b1; #1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_read_req && mem_grant) acc++;
            tick();
        end
        check_eq("bp_accepts", 32'(acc), 32'd4);
        check_eq("bp_req_off", {31'd0, mem_read_req}, 32'd0);
        check_eq("bp_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("bp_head_pc", instr_pc, 32'h0);
        check_eq("bp_head_instr", instr, 32'h1000);
        instr_ready = 1'b1; #1;
        check_eq("bp_resume_addr", mem_read_address, 32'h4);
        exp_pc = 0;
        for (int i = 0; i < 8; i++) begin
            if (instr_valid) begin
                check_eq("bp_drain_pc", instr_pc, 32'(exp_pc));
                check_eq("bp_drain_instr", instr, 32'h1000 + 32'(exp_pc));
                exp_pc++;
            end
            tick();
        end
        check_eq("bp_drain_count", 32'(exp_pc), 32'd8);

        // ---------------- Grant stall ----------------
        rst = 1'b1; tick();
        rst = 1'b0; instr_ready = 1'b1;
        acc = 0; exp_req = 0; exp_pc = 0;
        for (int i = 0; i < 12; i++) begin
            mem_grant = ((i % 2) == 0);
            #1;
            if (mem_read_req) check_eq("gs_addr", mem_read_address, 32'(exp_req));
            if (mem_read_req && mem_grant) begin
                exp_req++;
                acc++;
            end
            if (instr_valid) begin
                check_eq("gs_pc", instr_pc, 32'(exp_pc));
                check_eq("gs_instr", instr, 32'h1000 + 32'(exp_pc));
                exp_pc++;
            end
            tick();
        end
        check_eq("gs_accepts", 32'(acc), 32'd6);
        check_eq("gs_delivered", 32'(exp_pc), 32'd5);

        // ---------------- Redirect with in-flight request ----------------
        mem_grant = 1'b1;
        rst = 1'b1; tick();
        rst = 1'b0; instr_ready = 1'b1;
        repeat (5) tick();
        instr_ready = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
        check_eq("rd_pre_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("rd_pre_head", instr_pc, 32'h3);
        check_eq("rd_req_forced0", {31'd0, mem_read_req}, 32'd0);
        tick();
        redirect_valid = 1'b0; instr_ready = 1'b1; #1;
        check_eq("rd_flushed", {31'd0, instr_valid}, 32'd0);
        check_eq("rd_req_next", {31'd0, mem_read_req}, 32'd1);
        check_eq("rd_addr", mem_read_address, 32'h40);
        tick();
        check_eq("rd_drop_pc5", {31'd0, instr_valid}, 32'd0);
        tick();
        check_eq("rd_first_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("rd_first_pc", instr_pc, 32'h40);
        check_eq("rd_first_instr", instr, 32'h1040);
`ifdef IFU_STALL_COUNT_EN
        check_eq("stall_after_redirect", stall_cycles, 32'd4);
`endif
        tick();
        check_eq("rd_second_pc", instr_pc, 32'h41);
        check_eq("rd_second_instr", instr, 32'h1041);

        // ---------------- Wrap ----------------
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
        tick();
        redirect_valid = 1'b0; #1;
        check_eq("wr_flushed", {31'd0, instr_valid}, 32'd0);
        check_eq("wr_addr_top", mem_read_address, 32'hFFFF_FFFF);
        tick();
        check_eq("wr_addr_wrap", mem_read_address, 32'h0);
        tick();
        check_eq("wr_top_pc", instr_pc, 32'hFFFF_FFFF);
        check_eq("wr_top_instr", instr, 32'h0000_0FFF);
        tick();
        check_eq("wr_zero_pc", instr_pc, 32'h0);
        check_eq("wr_zero_instr", instr, 32'h1000);

        // ---------------- Redirect with pop ----------------
        redirect_valid = 1'b1; redirect_pc = 32'h80; #1;
        check_eq("rp_pop_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        redirect_valid = 1'b0; #1;
        check_eq("rp_empty", {31'd0, instr_valid}, 32'd0);
        check_eq("rp_addr", mem_read_address, 32'h80);
        tick(); tick();
        check_eq("rp_next_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("rp_next_pc", instr_pc, 32'h80);

        // ---------------- Reset beats redirect ----------------
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h99; #1;
        tick();
        rst = 1'b0; redirect_valid = 1'b0; #1;
        check_eq("rr_addr", mem_read_address, 32'h0);
        check_eq("rr_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rr_instr", instr, 32'h0);
        check_eq("rr_pc", instr_pc, 32'h0);
        check_eq("rr_req", {31'd0, mem_read_req}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Prefetching instruction fetch stage; sits directly upstream of the issue register and decoder.
- Generates word-addressed fetch requests to the main memory read port and buffers returned instructions in a small FIFO.
- Presents instructions with their PC to issue over a valid/ready handshake.
- Supports redirect (PC reload plus flush) from the PC-update logic.

Parameters:
- DEPTH, 4: prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0: fetch PC after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mem_read_address  output  32  word address of the fetch request
- mem_read_req  output  1  fetch request issued this cycle
- mem_grant  input  1  read port available to fetch this cycle; request accepted only when mem_read_req && mem_grant
- mem_read_data  input  32  instruction word; valid the cycle after an accepted request
- instr_valid  output  1  FIFO head holds a valid instruction
- instr_ready  input  1  issue stage accepts the head this cycle
- instr  output  32  FIFO head instruction word
- instr_pc  output  32  PC of the FIFO head
- redirect_valid  input  1  load a new fetch PC and flush
- redirect_pc  input  32  new fetch PC

Behaviour:
- Reset: fetch_pc=RESET_PC, FIFO empty, no request in flight, squash=0.
  - Outputs after reset: instr_valid=0, mem_read_req=0, instr=0, instr_pc=0.
- Request rule:
  - mem_read_req = !rst && !redirect_valid && (count + inflight) < DEPTH.
  - mem_read_address = fetch_pc.
- Request accept: accepted when mem_read_req && mem_grant.
  - On accept: fetch_pc <= fetch_pc + 1 (32-bit wrap, 32'hFFFFFFFF -> 0); inflight <= 1; captured PC recorded.
  - At most one request in flight. A new request may be accepted in the same cycle the previous response returns, giving back-to-back throughput of 1 per cycle.
- Response: in the cycle after an accept, mem_read_data and the captured PC are pushed to the FIFO tail, unless squash=1.
- Latency: request accepted in cycle N -> data pushed at end of N+1 -> instr_valid=1 in N+2. There is no bypass.
- Pop: when instr_valid && instr_ready, head advances at the clock edge.
  - Simultaneous push and pop on a full FIFO is legal; count stays unchanged.
- Output timing: instr and instr_pc are driven from FIFO head storage. When empty, they hold their last values; only instr_valid is meaningful.
- Full: no new request while count + inflight == DEPTH. The in-flight response always has a reserved slot, so an overflow is impossible.
- Empty with instr_ready=1: no pop, no state change.
- Redirect (redirect_valid=1), at the clock edge:
  - FIFO flushed (count <= 0).
  - fetch_pc <= redirect_pc.
  - Any in-flight response is discarded: squash set if inflight, cleared on the discarded return cycle.
  - mem_read_req forced 0 in the redirect cycle.
  - First new request is issued in the cycle after the redirect.
- Redirect and pop in the same cycle: the pop handshake completes (issue consumed the head), then the flush applies.
- Back-to-back redirects: the last one wins; squash logic still discards every stale return.
- Reset mid-operation: overrides everything, including a redirect, and returns to the reset state next cycle.

Optional Feature:
- Macro: IFU_STALL_COUNT_EN.
- With the macro defined:
  - Extra output port stall_cycles [31:0].
  - Increments each cycle where instr_ready=1 && instr_valid=0.
  - Saturates at 32'hFFFFFFFF.
  - Reset to 0 by rst; not cleared by redirect.
- Without the macro: port absent, no counter logic.

Test Plan:
- Cold start: rst high 2 cycles then low, mem_grant=1, memory holds word[i]=0x1000+i, instr_ready=1.
  - instr_valid first high 2 cycles after rst falls with instr=0x1000, instr_pc=0.
  - Then one instruction per cycle, PCs 1, 2, 3...
- Backpressure: instr_ready=0, mem_grant=1.
  - Exactly DEPTH=4 requests accepted, then mem_read_req=0 and instr_valid=1 holding PC 0.
  - Raise instr_ready: PCs 0..3 drain in order, fetch resumes at PC 4.
- Grant stall: mem_grant toggles 1,0,1,0.
  - Accepted fetches only on grant cycles; mem_read_address holds while grant=0; no duplicate or skipped PCs.
- Redirect with in-flight request: redirect_valid with redirect_pc=0x40 while a request for PC 5 is in flight and the FIFO holds 2 entries.
  - Next cycle instr_valid=0 and the PC 5 data is dropped.
  - Next delivered instruction has instr_pc=0x40, then 0x41.
- Wrap and simultaneous events: redirect to 0xFFFFFFFF.
  - Delivered PCs are 0xFFFFFFFF then 0x00000000.
  - Redirect asserted in the same cycle as a pop: the popped entry counts as consumed, the FIFO is empty afterward, and rst asserted in the same cycle wins with fetch_pc=RESET_PC.
- IFU_STALL_COUNT_EN: instr_ready=1 through reset release.
  - stall_cycles=2 when the first instruction appears.
  - Unchanged while instructions flow back-to-back.
  - Increments during the empty window after a redirect.
